// File: rtl/bram_rd_arbiter.sv
// Round-robin arbiter sharing one BRAM read port among NUM_REQ requesters, with loader writes passed through.
// Define BRAM_ARB_STATS_EN to build the saturating grant/conflict counters; otherwise they read as zero.
module bram_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arb_en,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  input  logic                    wr_valid,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    bram_rden,
  output logic [AW-1:0]           bram_rdaddr,
  input  logic [DATA_WIDTH-1:0]   bram_q,
  output logic                    bram_wren,
  output logic [AW-1:0]           bram_wraddr,
  output logic [DATA_WIDTH-1:0]   bram_wdata,
  output logic [NUM_REQ*32-1:0]   grant_cnt,
  output logic [31:0]             conflict_cnt
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

  logic [IW-1:0]      last_q;
  logic [NUM_REQ-1:0] rsp_owner_q;
  logic [AW-1:0]      rdaddr_q;
  logic [AW-1:0]      addr_arr [NUM_REQ];
  logic               found;
  logic [IW-1:0]      winner;
  logic [AW-1:0]      win_addr;
  logic [NUM_REQ-1:0] win_oh;
  logic               collide;
  logic               grant;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign addr_arr[i] = req_addr[i*AW +: AW];
  end

  // Scan upward from the requester after the last winner, wrapping; returns {found, index}.
  function automatic logic [IW:0] pick_winner(input logic [NUM_REQ-1:0] valid,
                                               input logic [IW-1:0]      last);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!res[IW] && valid[idx]) res = {1'b1, idx[IW-1:0]};
    end
    return res;
  endfunction

  assign {found, winner} = pick_winner(req_valid, last_q);
  assign win_addr = addr_arr[winner];
  assign win_oh   = NUM_REQ'(1) << winner;

  // A same-cycle write to the winner's address defers the read so it returns the new data.
  assign collide = wr_valid && (wr_addr == win_addr);
  assign grant   = rst_n && arb_en && found && !collide;

  assign req_ready   = grant ? win_oh : '0;
  assign bram_rden   = grant;
  assign bram_rdaddr = grant ? win_addr : rdaddr_q;

  assign rsp_valid = rsp_owner_q;
  assign rsp_data  = bram_q;

  assign bram_wren   = wr_valid;
  assign bram_wraddr = wr_addr;
  assign bram_wdata  = wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= LAST_RST;
      rsp_owner_q <= '0;
      rdaddr_q    <= '0;
    end else if (grant) begin
      last_q      <= winner;
      rsp_owner_q <= win_oh;
      rdaddr_q    <= win_addr;
    end else begin
      rsp_owner_q <= '0;
    end
  end

`ifdef BRAM_ARB_STATS_EN
  logic [31:0] grant_cnt_q [NUM_REQ];
  logic [31:0] conflict_cnt_q;
  logic        stall;

  assign stall = arb_en && found && collide;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
      conflict_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && (grant_cnt_q[i] != '1)) grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
      end
      if (stall && (conflict_cnt_q != '1)) conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    assign grant_cnt[i*32 +: 32] = grant_cnt_q[i];
  end
  assign conflict_cnt = conflict_cnt_q;
`else
  assign grant_cnt    = '0;
  assign conflict_cnt = '0;
`endif

endmodule

// File: doc/bram_rd_arbiter.md
# bram_rd_arbiter

Round-robin arbiter that shares the single read port of one `bram` instance between `NUM_REQ` datapath requesters, such as layer engines and the output dumper. It also passes the weight/activation loader's writes straight through to the write port. It sits between the MLP compute units and the activation/weight BRAM. It guarantees one read per cycle, a fixed 1-cycle response latency, and no same-cycle read/write address collision.

## Interface
- `NUM_REQ`, 4: number of read requesters (2..8).
- `DATA_WIDTH`, 16: BRAM word width.
- `DEPTH`, 1024: BRAM depth.
- `AW`, `$clog2(DEPTH)`: address width (derived; do not override).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `arb_en`  in  1  when low, no new read grants; in-flight response still completes.
- `req_valid`  in  NUM_REQ  per-requester read request.
- `req_addr`  in  NUM_REQ*AW  packed addresses; requester i at bits [i*AW +: AW].
- `req_ready`  out  NUM_REQ  one-hot grant; a request transfers when valid & ready.
- `rsp_valid`  out  NUM_REQ  one-hot; marks the requester owning `rsp_data` this cycle.
- `rsp_data`  out  DATA_WIDTH  read data, shared by all requesters.
- `wr_valid`  in  1  loader write strobe; always accepted.
- `wr_addr`  in  AW  write address.
- `wr_data`  in  DATA_WIDTH  write data.
- `bram_rden`  out  1  BRAM read enable.
- `bram_rdaddr`  out  AW  BRAM read address.
- `bram_q`  in  DATA_WIDTH  BRAM registered read data.
- `bram_wren`  out  1  BRAM write enable; equals `wr_valid`.
- `bram_wraddr`  out  AW  BRAM write address; equals `wr_addr`.
- `bram_wdata`  out  DATA_WIDTH  BRAM write data; equals `wr_data`.
- `grant_cnt`  out  NUM_REQ*32  per-requester grant counters (see Configuration).
- `conflict_cnt`  out  32  count of cycles stalled by a collision (see Configuration).

## Operation
- State:
  - `last_q`, the last-granted index, reset value `NUM_REQ-1`.
  - `rsp_owner_q`, a one-hot register, reset value 0.
  - The counters.
- Winner selection:
  - Search starts at index `(last_q+1) mod NUM_REQ` and scans upward with wrap-around.
  - The first i with `req_valid[i]=1` wins.
- A grant is issued when all of the following hold:
  - `arb_en=1`;
  - a winner exists;
  - there is no collision, i.e. not (`wr_valid=1` and `wr_addr == winner's addr`).
- On a grant:
  - `req_ready[winner]=1`, `bram_rden=1`, `bram_rdaddr` = winner's address;
  - on the clock edge, `last_q` ← winner and `rsp_owner_q` ← onehot(winner).
- Otherwise:
  - `req_ready` = 0 and `bram_rden` = 0;
  - `bram_rdaddr` holds the most recent granted address; it is a don't-care for checks;
  - `last_q` is unchanged, and `rsp_owner_q` ← 0 on the edge.
- Collision:
  - The read is deferred; it is retried the next cycle and sees the written data.
  - The pointer does not advance, so the same requester keeps priority.
- Response path:
  - `rsp_valid = rsp_owner_q`;
  - `rsp_data = bram_q` (pass-through);
  - `rsp_data` is undefined when `rsp_valid==0`.
- Responses have no backpressure; requesters must always accept them.
- Requests are independent single-beat transactions. A requester may hold `req_valid` across cycles and receive back-to-back grants only when it is the sole requester.
- `req_valid` and `req_addr` must stay stable until granted. The arbiter does not check this.

## Timing
- Grant decision is combinational from `req_valid`, `req_addr`, `wr_*`, `arb_en` and `last_q`, within the same cycle.
- Read latency:
  - a grant in cycle N gives `rsp_valid` plus data in cycle N+1;
  - exactly 1 cycle, fixed;
  - throughput is 1 read per cycle.
- Writes are not registered in the arbiter; a write in cycle N is visible to reads granted in cycle N+1 or later.
- While `rst_n=0`, asynchronously and regardless of inputs:
  - `req_ready`, `rsp_valid` and `bram_rden` = 0;
  - `last_q = NUM_REQ-1`;
  - counters = 0.
- Reset mid-operation: the pending response is dropped and `rsp_valid` is 0 immediately.
- Reset release: the first grant can occur in the first cycle with `rst_n=1`; requester 0 has priority.
- `arb_en` falling in cycle N: no grant in cycle N; a response granted in cycle N-1 still appears in cycle N.

## Configuration
- `BRAM_ARB_STATS_EN` defined:
  - `grant_cnt[i]` increments on each grant to requester i;
  - `conflict_cnt` increments on each cycle where a winner exists, `arb_en=1`, and a collision blocks the grant;
  - all counters are 32-bit and saturate at `0xFFFF_FFFF`.
- Not defined:
  - no counter flops;
  - `grant_cnt` and `conflict_cnt` are tied to 0;
  - ports remain present.

## Test plan
- Reset release with all 4 `req_valid=1` and addresses 0x10/0x20/0x30/0x40 → grants in order 0,1,2,3,0; each `rsp_valid` arrives 1 cycle later with the matching `bram_q` word (preloaded mem[a] = a).
- Only requester 2 valid for 5 cycles (addresses 5..9) → 5 consecutive grants; `rsp_data` = 5..9 in cycles N+1..N+5.
- Collision:
  - `wr_valid=1`, `wr_addr=0x44`, `wr_data=0xBEEF`, while the winner reads 0x44;
  - → no grant and `conflict_cnt`=1;
  - next cycle the same requester is granted and receives 0xBEEF.
- `arb_en=0` for 3 cycles with all requesters valid → `req_ready`=0 and `bram_rden`=0 throughout; after re-enable, the pointer resumes from `last_q+1`.
- `rst_n` asserted in the cycle after a grant → `rsp_valid` drops to 0 asynchronously; after release, requester 0 is granted first.
- With `BRAM_ARB_STATS_EN`, 12 round-robin grants over 4 requesters → `grant_cnt` = 3,3,3,3; without the macro, all counters read 0.
